// File: rtl/imm_encode_loader_if.sv
// Request and instruction-memory write bundle for imm_encode_loader.
interface imm_encode_loader_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            ImmSrc;
   logic [31:0]           base_instr;
   logic [31:0]           imm;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_data;
   logic [ADDR_WIDTH:0]   count;
   logic                  err;
   logic [1:0]            err_code;

   modport master (
      output in_valid, ImmSrc, base_instr, imm,
      input  in_ready, wr_en, wr_addr, wr_data, count, err, err_code
   );

   modport slave (
      input  in_valid, ImmSrc, base_instr, imm,
      output in_ready, wr_en, wr_addr, wr_data, count, err, err_code
   );
endinterface

// File: rtl/imm_encode_loader.sv
// Packs a signed immediate into I/S/B/J instruction fields and writes the word to
// consecutive instruction-memory addresses, parking when memory is full.
module imm_encode_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   imm_encode_loader_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StEncode, StWrite, StFull} state_e;

   localparam logic [ADDR_WIDTH:0] CountOne  = 1;
   localparam logic [ADDR_WIDTH:0] CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [1:0]          ErrRange  = 2'b01;
   localparam logic [1:0]          ErrAlign  = 2'b10;

   state_e              state_q, state_d;
   logic [1:0]          src_q, src_d;
   logic [31:0]         base_q, base_d;
   logic [31:0]         imm_q, imm_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic [31:0] enc;
   logic [1:0]  chk;

   // Field packing and legality of the latched request; chk is 00 when legal.
   always_comb begin
      enc = base_q;
      chk = 2'b00;
      unique case (src_q)
         2'b00: begin
            enc[31:20] = imm_q[11:0];
            if (!(&imm_q[31:11] || ~|imm_q[31:11])) chk = ErrRange;
         end
         2'b01: begin
            enc[31:25] = imm_q[11:5];
            enc[11:7]  = imm_q[4:0];
            if (!(&imm_q[31:11] || ~|imm_q[31:11])) chk = ErrRange;
         end
         2'b10: begin
            enc[31]    = imm_q[12];
            enc[7]     = imm_q[11];
            enc[30:25] = imm_q[10:5];
            enc[11:8]  = imm_q[4:1];
            if (imm_q[0]) chk = ErrAlign;
            else if (!(&imm_q[31:12] || ~|imm_q[31:12])) chk = ErrRange;
         end
         default: begin
            enc[31]    = imm_q[18];
            enc[19:12] = imm_q[18:11];
            enc[20]    = imm_q[10];
            enc[30:21] = imm_q[9:0];
            if (!(&imm_q[31:18] || ~|imm_q[31:18])) chk = ErrRange;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      base_d     = base_q;
      imm_d      = imm_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      count_d    = count_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               src_d   = bus.ImmSrc;
               base_d  = bus.base_instr;
               imm_d   = bus.imm;
               state_d = StEncode;
            end
         end
         StEncode: begin
            wr_data_d = enc;
            if (chk == 2'b00) begin
               wr_en_d = 1'b1;
               state_d = StWrite;
            end else begin
               // Only the first error is recorded; the request is dropped.
               if (!err_q) begin
                  err_d      = 1'b1;
                  err_code_d = chk;
               end
               state_d = StIdle;
            end
         end
         StWrite: begin
            count_d = count_q + CountOne;
            state_d = (count_d == CountFull) ? StFull : StIdle;
         end
         default: state_d = StFull;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         src_q      <= 2'b00;
         base_q     <= '0;
         imm_q      <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         count_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         base_q     <= base_d;
         imm_q      <= imm_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         count_q    <= count_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.in_ready = (state_q == StIdle) && !rst;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = count_q[ADDR_WIDTH-1:0];
   assign bus.wr_data  = wr_data_q;
   assign bus.count    = count_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Vector-table and scoreboard bench for imm_encode_loader with a 4-word memory.
module tb_imm_encode_loader;

   localparam int unsigned AW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imm_encode_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imm_encode_loader #(.ADDR_WIDTH(AW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit          rst_before;
      logic [1:0]  src;
      logic [31:0] base;
      logic [31:0] imm;
      logic [1:0]  code;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          rt;
      logic [1:0]  src;
      logic [31:0] base;
      logic [31:0] imm;
   } wr_t;

   wr_t  exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   mcount = 0;
   bit   merr   = 1'b0;
   logic [1:0] mcode = 2'b00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] d);
      case (src)
         2'b00:   return {{20{d[31]}}, d[31:20]};
         2'b01:   return {{20{d[31]}}, d[31:25], d[11:7]};
         2'b10:   return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
         default: return {{13{d[31]}}, d[19:12], d[20], d[30:21]};
      endcase
   endfunction

   function automatic logic [31:0] field_mask(input logic [1:0] src);
      case (src)
         2'b00:   return 32'hFFF0_0000;
         2'b01:   return 32'hFE00_0F80;
         2'b10:   return 32'hFE00_0F80;
         default: return 32'hFFFF_F000;
      endcase
   endfunction

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && bus.wr_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h want no write",
                     bus.wr_addr, bus.wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.wr_addr), e.addr);
            if (e.rt) begin
               check("roundtrip", decode(e.src, bus.wr_data), e.imm);
               check("passthru", bus.wr_data & ~field_mask(e.src), e.base & ~field_mask(e.src));
            end else begin
               check("wr_data", bus.wr_data, e.data);
            end
         end
      end
   end

   task automatic do_reset();
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_err", {bus.err, 29'd0, bus.err_code}, 32'd0);
      rst = 1'b0;
      mcount = 0;
      merr = 1'b0;
      mcode = 2'b00;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic send(input logic [1:0] src, input logic [31:0] base, input logic [31:0] imm,
                       input logic [1:0] code, input logic [31:0] data, input bit rt);
      int k = 0;
      bus.ImmSrc = src;
      bus.base_instr = base;
      bus.imm = imm;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (code == 2'b00) begin
         exp_q.push_back('{addr: 32'(mcount % 4), data: data, rt: rt, src: src, base: base,
                           imm: imm});
         mcount++;
      end else if (!merr) begin
         merr = 1'b1;
         mcode = code;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("encode_wr_en", 32'(bus.wr_en), 32'd0);
      check("encode_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("write_wr_en", 32'(bus.wr_en), 32'(code == 2'b00));
      @(negedge clk);
      check("count", 32'(bus.count), 32'(mcount));
      check("err", {bus.err, 29'd0, bus.err_code}, {merr, 29'd0, mcode});
      check("in_ready", 32'(bus.in_ready), 32'(mcount != 4));
   endtask

   vec_t vecs[14];

   initial begin
      bus.in_valid = 1'b0;
      bus.ImmSrc = 2'b00;
      bus.base_instr = '0;
      bus.imm = '0;

      vecs[0]  = '{1, 2'b00, 32'h0000_0093, 32'hFFFF_FFFF, 2'b00, 32'hFFF0_0093};
      vecs[1]  = '{1, 2'b01, 32'h0020_2023, 32'h0000_07FF, 2'b00, 32'h7E20_2FA3};
      vecs[2]  = '{0, 2'b10, 32'h0000_0063, 32'hFFFF_FFFC, 2'b00, 32'hFE00_0EE3};
      vecs[3]  = '{1, 2'b10, 32'h0000_0063, 32'h0000_0003, 2'b10, 32'h0};
      vecs[4]  = '{0, 2'b00, 32'h0000_0013, 32'h0000_0800, 2'b01, 32'h0};
      vecs[5]  = '{0, 2'b00, 32'h0000_0013, 32'h0000_0005, 2'b00, 32'h0050_0013};
      vecs[6]  = '{1, 2'b11, 32'h0000_00EF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_F0EF};
      vecs[7]  = '{0, 2'b11, 32'h0000_00EF, 32'h0004_0000, 2'b01, 32'h0};
      vecs[8]  = '{0, 2'b10, 32'h0000_0063, 32'hFFFF_EFFE, 2'b01, 32'h0};
      vecs[9]  = '{1, 2'b10, 32'h0000_0063, 32'h0000_1001, 2'b10, 32'h0};
      vecs[10] = '{0, 2'b01, 32'h0000_0023, 32'hFFFF_F800, 2'b00, 32'h8000_0023};
      vecs[11] = '{0, 2'b00, 32'h0000_0013, 32'h0000_07FF, 2'b00, 32'h7FF0_0013};
      vecs[12] = '{0, 2'b10, 32'h0000_0063, 32'h0000_0FFE, 2'b00, 32'h7E00_0FE3};
      vecs[13] = '{0, 2'b11, 32'h0000_006F, 32'hFFFC_0000, 2'b00, 32'h8008_006F};

      repeat (2) @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].rst_before) do_reset();
         send(vecs[i].src, vecs[i].base, vecs[i].imm, vecs[i].code, vecs[i].data, 1'b0);
      end

      // Memory is full: further requests are refused and nothing is written.
      bus.ImmSrc = 2'b00;
      bus.base_instr = 32'h0000_0013;
      bus.imm = 32'd1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("full_in_ready", 32'(bus.in_ready), 32'd0);
      end
      check("full_count", 32'(bus.count), 32'd4);
      bus.in_valid = 1'b0;
      do_reset();

      // Reset during ENCODE drops the request.
      bus.ImmSrc = 2'b00;
      bus.base_instr = 32'h0000_0013;
      bus.imm = 32'd9;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
      end
      check("midrst_count", 32'(bus.count), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      send(2'b00, 32'h0000_0013, 32'd7, 2'b00, 32'h0070_0013, 1'b0);

      // Random legal J immediates must survive sign-extension decode.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] r;
         r = 32'($urandom_range(0, 524287)) - 32'd262144;
         send(2'b11, $urandom(), r, 2'b00, 32'h0, 1'b1);
      end

      repeat (2) @(negedge clk);
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
